alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request at a time, holds the operands on the
// ALU for SETTLE cycles, captures the ALU outputs and presents them as a response.
// Op codes above MAX_OP skip the ALU and return an error response immediately.
module alu_op_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned MAX_OP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_fsel,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_mul_high,
  input  logic [3:0] alu_sreg,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [7:0] rsp_mul_high,
  output logic [3:0] rsp_sreg,
  output logic       rsp_err,
  output logic [7:0] op_count
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            req_ready_nxt;
  logic            rsp_valid_nxt;
  logic [DW-1:0]   alu_a_nxt;
  logic [DW-1:0]   alu_b_nxt;
  logic [OPW-1:0]  alu_fsel_nxt;
  logic [DW-1:0]   rsp_result_nxt;
  logic [DW-1:0]   rsp_mul_high_nxt;
  logic [SW-1:0]   rsp_sreg_nxt;
  logic            rsp_err_nxt;
  logic [DW-1:0]   op_count_nxt;

  logic accept_c;
  logic op_legal_c;
  logic settled_c;

  assign accept_c   = req_valid && req_ready;
  assign op_legal_c = (32'(req_op) <= MAX_OP);
  assign settled_c  = (cnt == CW'(0));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fsel     <= '0;
      rsp_result   <= '0;
      rsp_mul_high <= '0;
      rsp_sreg     <= '0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      req_ready    <= req_ready_nxt;
      rsp_valid    <= rsp_valid_nxt;
      alu_a        <= alu_a_nxt;
      alu_b        <= alu_b_nxt;
      alu_fsel     <= alu_fsel_nxt;
      rsp_result   <= rsp_result_nxt;
      rsp_mul_high <= rsp_mul_high_nxt;
      rsp_sreg     <= rsp_sreg_nxt;
      rsp_err      <= rsp_err_nxt;
      op_count     <= op_count_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          state_nxt = op_legal_c ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (settled_c) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; handshake flags follow the next state
  always_comb begin
    cnt_nxt          = cnt;
    alu_a_nxt        = alu_a;
    alu_b_nxt        = alu_b;
    alu_fsel_nxt     = alu_fsel;
    rsp_result_nxt   = rsp_result;
    rsp_mul_high_nxt = rsp_mul_high;
    rsp_sreg_nxt     = rsp_sreg;
    rsp_err_nxt      = rsp_err;
    op_count_nxt     = op_count;
    req_ready_nxt    = (state_nxt == S_IDLE);
    rsp_valid_nxt    = (state_nxt == S_RESP);
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          alu_a_nxt = req_a;
          alu_b_nxt = req_b;
          if (op_legal_c) begin
            alu_fsel_nxt = req_op;
            cnt_nxt      = SETTLE_LD;
          end else begin
            // Illegal code never reaches the ALU; answer with a zeroed error response
            alu_fsel_nxt     = '0;
            rsp_result_nxt   = '0;
            rsp_mul_high_nxt = '0;
            rsp_sreg_nxt     = '0;
            rsp_err_nxt      = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (settled_c) begin
          rsp_result_nxt   = alu_result;
          rsp_mul_high_nxt = alu_mul_high;
          rsp_sreg_nxt     = alu_sreg;
          rsp_err_nxt      = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_nxt = op_count + DW'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

endmodule
